// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: bit-timing and framing controller for the serial receive path.
// It synchronizes the raw line, finds the start bit and emits one shift strobe
// at the centre of each data bit for the external shift register. After a good
// stop bit it copies the register's parallel word into a holding buffer.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   serial_in       raw asynchronous serial line (idles high)
//   sr_data         parallel word from the downstream shift register
//   data_read       consumer acknowledge pulse for rx_data
//   rx_serial_sync  synchronized line, feeds the shift register's serial input
//   shift_strobe    one-cycle pulse at each data-bit centre
//   rx_data         last good received word
//   data_ready      rx_data holds unread data
//   overrun_error   a good word was loaded while the previous one was unread
//   framing_error   the last frame's stop bit sampled low
//   busy            controller is inside a frame
module rx_frame_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic [DATA_BITS-1:0] sr_data,
  input  logic                 data_read,
  output logic                 rx_serial_sync,
  output logic                 shift_strobe,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  // The counter starts at 0 the cycle after the event that cleared it, so
  // "N cycles later" is reached when it holds N-1.
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  // Strobe is registered: request it one cycle ahead of the bit centre.
  localparam logic [CW-1:0] STB_AT  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [BW-1:0]  bit_cnt, bit_cnt_nx;
  logic           strobe_nx;
  logic           sync1, prev;
  logic           was_ready;
  logic           stop_good, stop_bad;

  assign busy      = (state != IDLE);
  assign stop_good = (state == STOP) && (cnt == BIT_END) &&  rx_serial_sync;
  assign stop_bad  = (state == STOP) && (cnt == BIT_END) && !rx_serial_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1          <= 1'b1;
      rx_serial_sync <= 1'b1;
      prev           <= 1'b1;
      state          <= IDLE;
      cnt            <= '0;
      bit_cnt        <= '0;
      shift_strobe   <= 1'b0;
    end else begin
      sync1          <= serial_in;
      rx_serial_sync <= sync1;
      prev           <= rx_serial_sync;
      state          <= state_nx;
      cnt            <= cnt_nx;
      bit_cnt        <= bit_cnt_nx;
      shift_strobe   <= strobe_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    bit_cnt_nx = bit_cnt;
    strobe_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        // Edge-based: a line stuck low after a framing error never restarts.
        if (prev && !rx_serial_sync) state_nx = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nx     = '0;
          bit_cnt_nx = '0;
          state_nx   = rx_serial_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        strobe_nx = (cnt == STB_AT);
        if (cnt == BIT_END) begin
          cnt_nx = '0;
          if (bit_cnt == LAST_BIT) state_nx = STOP;
          else                     bit_cnt_nx = bit_cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_nx   = '0;
          state_nx = rx_serial_sync ? LOAD : IDLE;
        end
      end
      LOAD: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The word becomes visible on entry to LOAD. The overrun decision is made
  // during LOAD from the readiness captured just before the load, so a read
  // pulse landing in LOAD cancels the overrun but never clears the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
      was_ready     <= 1'b0;
    end else if (stop_good) begin
      rx_data       <= sr_data;
      data_ready    <= 1'b1;
      framing_error <= 1'b0;
      was_ready     <= data_ready && !data_read;
    end else if (state == LOAD) begin
      overrun_error <= was_ready && !data_read;
    end else begin
      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      if (stop_bad) framing_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: a behavioural shift register is attached, frames
// are driven from a table of {word, stop bit, read pulses, expected flags},
// and strobe times are tracked by a scoreboard queue filled at frame start.
module tb_rx_frame_ctrl;
  localparam int CPB = 10;
  localparam int DB  = 8;
  localparam int H   = CPB / 2;

  logic          clk;
  logic          rst;
  logic          serial_in;
  logic [DB-1:0] sr_data;
  logic          data_read;
  logic          rx_serial_sync;
  logic          shift_strobe;
  logic [DB-1:0] rx_data;
  logic          data_ready;
  logic          overrun_error;
  logic          framing_error;
  logic          busy;

  rx_frame_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .sr_data(sr_data),
    .data_read(data_read), .rx_serial_sync(rx_serial_sync),
    .shift_strobe(shift_strobe), .rx_data(rx_data), .data_ready(data_ready),
    .overrun_error(overrun_error), .framing_error(framing_error), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // LSB-first shift register, sampling the synchronized line on the strobe
  always @(posedge clk) begin
    if (rst)               sr_data <= '0;
    else if (shift_strobe) sr_data <= {rx_serial_sync, sr_data[DB-1:1]};
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event monitor and strobe scoreboard, sampled on the falling edge
  int exp_strobe[$];
  int busy_rise, busy_fall, fe_rise, dr_rise;
  bit busy_q, fe_q, dr_q;
  always @(negedge clk) begin
    int e_t;
    if (busy === 1'b1 && !busy_q) busy_rise = cyc;
    if (busy === 1'b0 &&  busy_q) busy_fall = cyc;
    if (framing_error === 1'b1 && !fe_q) fe_rise = cyc;
    if (data_ready === 1'b1 && !dr_q) dr_rise = cyc;
    busy_q = (busy === 1'b1);
    fe_q   = (framing_error === 1'b1);
    dr_q   = (data_ready === 1'b1);
    if (shift_strobe === 1'b1) begin
      e_t = (exp_strobe.size() > 0) ? exp_strobe.pop_front() : -1;
      chk("strobe_time", cyc, e_t);
    end
  end

  // Drives one frame; rst_c >= 0 pulses rst at cycle E+rst_c and idles the line.
  task automatic frame(input logic [7:0] d, input bit stop, input bit rd_load,
                       input int rst_c, output int e);
    int n, t, b;
    n = cyc;
    e = n + 2;
    for (int k = 0; k < DB; k++) begin
      t = e + H + (k + 1) * CPB;
      if (rst_c < 0 || t < e + rst_c) exp_strobe.push_back(t);
    end
    for (int c = 0; c < (DB + 2) * CPB; c++) begin
      b = c / CPB;
      if (b == 0)       serial_in = 1'b0;
      else if (b <= DB) serial_in = d[b-1];
      else              serial_in = stop;
      data_read = rd_load && (c == 3 + H + (DB + 1) * CPB);
      rst = (rst_c >= 0) && (c == rst_c + 2);
      if (rst_c >= 0 && c > rst_c + 2) serial_in = 1'b1;
      tick();
    end
    serial_in = 1'b1;
    data_read = 1'b0;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    bit stop, rd_load, rd_after;
    bit e_rdy, e_ovr, e_fe;
    logic [7:0] e_rx;
  } vec_t;

  vec_t tbl[8];
  int e;
  bit rdy0, fe0, ovr0;

  initial begin
    tbl[0] = '{8'hA5, 1, 0, 1, 1, 0, 0, 8'hA5};
    tbl[1] = '{8'h3C, 0, 0, 0, 0, 0, 1, 8'hA5};
    tbl[2] = '{8'h5A, 1, 0, 1, 1, 0, 0, 8'h5A};
    tbl[3] = '{8'h11, 1, 0, 0, 1, 0, 0, 8'h11};
    tbl[4] = '{8'h22, 1, 0, 1, 1, 1, 0, 8'h22};
    tbl[5] = '{8'h33, 1, 0, 0, 1, 0, 0, 8'h33};
    tbl[6] = '{8'h44, 1, 1, 1, 1, 0, 0, 8'h44};
    tbl[7] = '{8'h0F, 0, 0, 0, 0, 0, 1, 8'h44};

    rst = 1'b1;
    serial_in = 1'b1;
    data_read = 1'b0;
    tick();
    // Reset held while the line toggles
    for (int i = 0; i < 12; i++) begin
      serial_in = 1'($urandom_range(0, 1));
      tick();
      chk("reset_outputs", {rx_serial_sync, shift_strobe, data_ready, overrun_error,
                            framing_error, busy, 2'b00, rx_data}, {8'b1000_0000, 8'h00});
    end
    serial_in = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();

    foreach (tbl[i]) begin
      rdy0 = data_ready;
      busy_rise = -1; busy_fall = -1; fe_rise = -1; dr_rise = -1;
      frame(tbl[i].d, tbl[i].stop, tbl[i].rd_load, -1, e);
      chk("busy_rise", busy_rise, e + 1);
      chk("busy_fall", busy_fall, tbl[i].stop ? e + 97 : e + 96);
      if (!tbl[i].stop) chk("framing_rise", fe_rise, e + 96);
      if (tbl[i].stop && !rdy0) chk("ready_rise", dr_rise, e + 96);
      chk("rx_data", rx_data, tbl[i].e_rx);
      chk("data_ready", data_ready, tbl[i].e_rdy);
      chk("overrun", overrun_error, tbl[i].e_ovr);
      chk("framing", framing_error, tbl[i].e_fe);
      chk("strobes_left", exp_strobe.size(), 0);
      if (tbl[i].rd_after) begin
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
      end
      repeat (3) tick();
    end

    // Glitch: three low cycles is a false start
    rdy0 = data_ready; fe0 = framing_error; ovr0 = overrun_error;
    busy_rise = -1; busy_fall = -1;
    e = cyc + 2;
    serial_in = 1'b0;
    repeat (3) tick();
    serial_in = 1'b1;
    repeat (20) tick();
    chk("glitch_busy_rise", busy_rise, e + 1);
    chk("glitch_busy_fall", busy_fall, e + 6);
    chk("glitch_flags", {data_ready, overrun_error, framing_error}, {rdy0, ovr0, fe0});

    // Reset in the middle of a frame
    frame(8'h00, 1'b1, 1'b0, 40, e);
    repeat (20) tick();
    chk("abort_state", {busy, data_ready, overrun_error, framing_error}, 4'b0000);
    chk("abort_rx_data", rx_data, 8'h00);
    chk("abort_strobes_left", exp_strobe.size(), 0);

    dr_rise = -1;
    frame(8'h5A, 1'b1, 1'b0, -1, e);
    chk("after_abort_ready_rise", dr_rise, e + 96);
    chk("after_abort_rx_data", rx_data, 8'h5A);
    chk("after_abort_flags", {data_ready, overrun_error, framing_error}, 3'b100);
    chk("after_abort_strobes_left", exp_strobe.size(), 0);

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Bit-timing and framing controller for the serial receive path, sitting directly upstream of the 8-bit serial-to-parallel shift register. It synchronizes the raw serial line, detects a start bit, and generates one-cycle shift strobes at each data-bit centre. It also checks the stop bit and latches the shift register's parallel word into a holding buffer with ready, overrun and framing flags for the downstream consumer.

## Interface
- CLKS_PER_BIT, 10, clock cycles per serial bit; legal range is 4 or more. H = CLKS_PER_BIT/2 (integer division).
- DATA_BITS, 8, data bits per frame; legal range 1..16.
- Reset is synchronous and active-high, on one clock. The ports are named clk and rst.
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous active-high reset.
- serial_in  in  1  raw asynchronous serial line; idles high.
- sr_data  in  DATA_BITS  parallel output of the downstream shift register.
- data_read  in  1  consumer pulse that acknowledges rx_data.
- rx_serial_sync  out  1  synchronized line; drives the shift register's serial_in.
- shift_strobe  out  1  one-cycle pulse; drives the shift register's shift_enable.
- rx_data  out  DATA_BITS  last good received word.
- data_ready  out  1  rx_data holds unread data.
- overrun_error  out  1  a good word was loaded while data_ready was still set.
- framing_error  out  1  the last frame's stop bit sampled low.
- busy  out  1  the FSM is not in IDLE.

## Operation
- Synchronizer: 2 flops on serial_in, both reset to 1. rx_serial_sync is the second flop. A third flop, prev, also resets to 1 and is used for edge detection.
- States: IDLE, START, DATA, STOP, LOAD. There is one cycle counter, sized for CLKS_PER_BIT, and one bit counter, sized for DATA_BITS.
- IDLE: a falling edge (prev=1, rx_serial_sync=0) moves the FSM to START and clears the cycle counter. That edge cycle is called E.
- START: at cycle E+H, sample rx_serial_sync.
  - If it is 0, go to DATA and clear both counters.
  - If it is 1, treat it as a false start and go to IDLE with no strobe.
- DATA: assert shift_strobe for exactly one cycle at E+H+(k+1)·CLKS_PER_BIT, for k = 0..DATA_BITS-1. After the last strobe, go to STOP.
- STOP: sample at S = E+H+(DATA_BITS+1)·CLKS_PER_BIT.
  - If the sample is 1, go to LOAD.
  - If the sample is 0, set framing_error, go to IDLE, and leave rx_data and data_ready unchanged.
- LOAD (cycle S+1):
  - rx_data ← sr_data, data_ready ← 1, framing_error ← 0.
  - overrun_error ← 1 if data_ready was 1 and data_read is 0 in this cycle.
  - Next state is IDLE.
- data_read:
  - Outside LOAD: clears data_ready and overrun_error at the next edge.
  - During LOAD: the load wins. data_ready stays 1 and overrun is not set.
- After a framing error the line may still be low. A new frame then requires the line to return high before a falling edge can be detected, because detection is edge-based and not level-based.
- rst at any time, mid-frame included, returns every register to its reset value on the next edge. No strobe or load is issued afterwards for the aborted frame.
- busy = (state != IDLE).

## Timing
- Reset values: rx_serial_sync=1, shift_strobe=0, rx_data=0, data_ready=0, overrun_error=0, framing_error=0, busy=0. State is IDLE and the counters are 0.
- Line-to-sync latency is 2 cycles. A raw falling edge registered at cycle t gives E = t+2.
- shift_strobe is registered, never asserted in two consecutive cycles, and issued exactly DATA_BITS times per valid frame.
- The shift register samples rx_serial_sync in the same cycle as the strobe, so each bit is taken at its centre.
- Load latency: rx_data and data_ready update at S+1. The earliest next start edge is detected at S+2.
- busy goes high at E+1 and low at the first cycle back in IDLE:
  - E+H+1 for a false start,
  - S+1 for a framing error,
  - S+2 for a good frame.

## Test plan
- Reset: hold rst with serial_in toggling. Every output equals its reset value and shift_strobe never pulses.
- Nominal frame, CLKS_PER_BIT=10, DATA_BITS=8, real shift register attached. Send 0xA5 LSB-first with stop bit 1.
  - 8 strobes at E+15, 25, …, 85.
  - Stop sample at E+95.
  - At E+96, data_ready=1 and rx_data equals the register's word. The flags are 0.
- Glitch: serial_in low for 3 cycles, then high. No strobe, busy drops at E+6, flags unchanged.
- Framing error: valid data 0x3C with a low stop bit. framing_error=1 at E+96, data_ready stays 0, rx_data is unchanged. A following good frame clears framing_error on its load.
- Overrun and read collision:
  - Two good frames (0x11 then 0x22) with no data_read: overrun_error=1 and rx_data=0x22.
  - Repeat with data_read pulsed exactly at the second LOAD cycle: data_ready=1 and overrun_error=0.
- Reset mid-frame: assert rst at E+40 for 1 cycle, then idle the line. No further strobes and no load. After a subsequent good frame 0x5A, rx_data=0x5A.
